key_input_ctrl: RTL and testbench
=================================

Name: key_input_ctrl

Overview:
Board push-button input block; the input-side counterpart of the LED output blocks. It takes NUM_KEYS raw mechanical buttons and synchronizes, debounces and edge-detects each one, and detects long presses. Outputs are clean levels, single-cycle press/release/long-press pulses and a running press count. The pulses and count can drive LED or counter logic directly.

Parameters:
NUM_KEYS, 4, number of button inputs
DB_CYC, 2000000, debounce window in clock cycles (20 ms at 100 MHz); minimum 2
LONG_CYC, 100000000, hold time in cycles, counted from the key_press cycle, that flags a long press (1 s at 100 MHz); must be greater than DB_CYC
ACTIVE_LOW, 1, 1 = raw button reads 0 when pressed; 0 = raw button reads 1 when pressed
CNT_W, 8, press_cnt width

Ports:
clock  input  1  system clock
n_reset  input  1  asynchronous active-low reset
key_in  input  NUM_KEYS  raw asynchronous button pins
key_level  output  NUM_KEYS  debounced pressed level, 1 = pressed
key_press  output  NUM_KEYS  1-cycle pulse on debounced press
key_release  output  NUM_KEYS  1-cycle pulse on debounced release
key_long  output  NUM_KEYS  1-cycle pulse when a hold reaches LONG_CYC
press_cnt  output  CNT_W  total debounced presses, all keys

Behaviour:
- Reset: n_reset, asynchronous, active-low; clock clock. All outputs 0, all FSMs IDLE, all counters 0, synchronizers loaded with the not-pressed value. Reset mid-operation aborts any debounce or hold and emits no pulses.
- Per key: 2-flop synchronizer, then polarity normalize (p = 1 means pressed).
- Debounce counter width: clog2(DB_CYC). Hold counter width: clog2(LONG_CYC).
- FSM states and transitions:
  - IDLE: if p=1, go to PRESS_DB and clear the debounce counter.
  - PRESS_DB: if p=0, return to IDLE with no pulse (glitch rejected). Otherwise count. When the counter reaches DB_CYC-1 with p still 1:
    - go to HELD;
    - assert key_press for 1 cycle;
    - set key_level to 1;
    - clear the hold counter and the long_done flag.
  - HELD: the hold counter increments each cycle while long_done=0. When it reaches LONG_CYC-1, pulse key_long for 1 cycle and set long_done; the counter then stops. If p=0, go to RELEASE_DB and clear the debounce counter; the hold counter freezes.
  - RELEASE_DB: if p=1, return to HELD with no pulse; the hold counter and long_done are kept. If p stays 0 until the counter reaches DB_CYC-1:
    - go to IDLE;
    - assert key_release for 1 cycle;
    - set key_level to 0.
- Latency: with a clean edge on key_in, key_press goes high DB_CYC+2 rising edges after the first edge that samples the new raw level. key_release has the same latency.
- Pulse rules: key_press and key_release never occur together on one key. key_long occurs at most once per press and never in the same cycle as that key's key_press.
- Keys are fully independent.
- press_cnt: each cycle add popcount(key_press), so simultaneous presses on several keys in one cycle all count. Arithmetic is modulo 2^CNT_W and wraps silently (255+1 = 0).
- Outputs are registered. Pulses are exactly one clock wide.

Decomposition:
- Shared package key_pkg: FSM state encoding (IDLE, PRESS_DB, HELD, RELEASE_DB) and a clog2 function.
- Sub-module key_channel: one per key, generated NUM_KEYS times. It contains the synchronizer, the FSM and both counters, and outputs level, press, release and long.
- Top key_input_ctrl: polarity parameter pass-through, popcount and press_cnt accumulator.

Test Plan:
Bench parameters: DB_CYC=4, LONG_CYC=16, ACTIVE_LOW=1, NUM_KEYS=4, CNT_W=8.
1. Clean press: key_in[0] driven 1->0 and held -> key_press[0] high for exactly 1 cycle, 6 edges after the first sample of 0; key_level[0]=1; press_cnt=1.
2. Glitch: key_in[1] low for 3 cycles, then high -> no pulses, key_level[1] stays 0, press_cnt unchanged.
3. Release bounce: while key 0 is held, key_in[0] high for 2 cycles then low again -> no key_release; then hold high for 10 cycles -> exactly one key_release[0] pulse and key_level[0]=0.
4. Long press: key 2 held for 30 cycles after key_press -> exactly one key_long[2] pulse, 15 cycles after key_press[2]. A 3-cycle release bounce before that point delays key_long by nothing beyond the frozen cycles.
5. Simultaneous and wrap: keys 0-3 pressed on the same edge with press_cnt=254 -> four key_press pulses in the same cycle; press_cnt becomes 2 (254+4 mod 256).
6. Reset mid-operation: n_reset asserted during PRESS_DB and during HELD -> all outputs are 0 immediately (asynchronous). After deassertion, a still-pressed key takes a full DB_CYC+2 edges to produce key_press.

Source files
------------

// File: rtl/key_pkg.sv
// Shared definitions for the push-button input block.
// Latency: n/a (types and an elaboration-time helper only).
// Backpressure: n/a.
//
// Contents:
//   key_state_t  per-key debounce/hold FSM encoding
//   clog2        counter width helper, never returns less than 1
package key_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } key_state_t;

  // Bits needed to hold the values 0 .. value-1. At least 1 bit, so that
  // a degenerate count of 1 or 2 still yields a legal vector width.
  function automatic int clog2(input longint unsigned value);
    int result;
    result = 1;
    for (int i = 1; i < 63; i++) begin
      if ((64'd1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/key_channel.sv
// One push-button: 2-flop synchronizer, polarity normalize, debounce FSM, hold timer.
// Latency: press/release pulse DB_CYC+2 edges after the first edge sampling a clean change.
// Backpressure: none; outputs are free-running registered levels and 1-cycle pulses.
//
// Ports:
//   clock, n_reset  system clock, asynchronous active-low reset
//   key_raw         raw asynchronous button pin
//   level           debounced pressed level (1 = pressed)
//   press           1-cycle pulse when a press is accepted
//   released        1-cycle pulse when a release is accepted
//   long_press      1-cycle pulse when the hold reaches LONG_CYC cycles after press
module key_channel
  import key_pkg::*;
#(
  parameter int unsigned DB_CYC     = 2000000,
  parameter int unsigned LONG_CYC   = 100000000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic clock,
  input  logic n_reset,
  input  logic key_raw,
  output logic level,
  output logic press,
  output logic released,
  output logic long_press
);

  localparam int DB_W   = clog2(DB_CYC);
  localparam int HOLD_W = clog2(LONG_CYC);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYC - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
  localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);

  // Raw pin value when the button is not pressed.
  localparam logic IDLE_RAW = ACTIVE_LOW;

  logic sync_a;
  logic sync_b;
  logic pressed;

  key_state_t        state;
  key_state_t        state_nxt;
  logic [DB_W-1:0]   db_cnt;
  logic [DB_W-1:0]   db_cnt_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_cnt_nxt;
  logic [HOLD_W-1:0] hold_inc;
  logic              long_done;
  logic              long_done_nxt;
  logic              level_nxt;
  logic              press_nxt;
  logic              released_nxt;
  logic              long_nxt;

  // Synchronizer resets to the idle pin level so that reset release never
  // looks like a button edge.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      sync_a <= IDLE_RAW;
      sync_b <= IDLE_RAW;
    end else begin
      sync_a <= key_raw;
      sync_b <= sync_a;
    end
  end

  // Normalized: 1 means the button is physically pressed.
  assign pressed  = sync_b ^ IDLE_RAW;
  assign hold_inc = hold_cnt + HOLD_ONE;

  always_comb begin
    state_nxt     = state;
    db_cnt_nxt    = db_cnt;
    hold_cnt_nxt  = hold_cnt;
    long_done_nxt = long_done;
    level_nxt     = level;
    press_nxt     = 1'b0;
    released_nxt  = 1'b0;
    long_nxt      = 1'b0;

    case (state)
      IDLE: begin
        if (pressed) begin
          state_nxt  = PRESS_DB;
          db_cnt_nxt = '0;
        end
      end

      PRESS_DB: begin
        if (!pressed) begin
          // Too short to be a press: drop it silently.
          state_nxt = IDLE;
        end else if (db_cnt == DB_LAST) begin
          state_nxt     = HELD;
          press_nxt     = 1'b1;
          level_nxt     = 1'b1;
          hold_cnt_nxt  = '0;
          long_done_nxt = 1'b0;
        end else begin
          db_cnt_nxt = db_cnt + DB_ONE;
        end
      end

      HELD: begin
        if (!pressed) begin
          // Hold timer freezes while a possible release is being debounced.
          state_nxt  = RELEASE_DB;
          db_cnt_nxt = '0;
        end else if (!long_done) begin
          // The pulse is raised on the edge the counter lands on its last
          // value, so it appears LONG_CYC-1 cycles after the press pulse.
          // The press cycle itself starts at 0, so key_long can never
          // coincide with key_press.
          hold_cnt_nxt = hold_inc;
          if (hold_inc == HOLD_LAST) begin
            long_nxt      = 1'b1;
            long_done_nxt = 1'b1;
          end
        end
      end

      RELEASE_DB: begin
        if (pressed) begin
          // Release bounce: resume the same hold, timer and long flag intact.
          state_nxt = HELD;
        end else if (db_cnt == DB_LAST) begin
          state_nxt    = IDLE;
          released_nxt = 1'b1;
          level_nxt    = 1'b0;
        end else begin
          db_cnt_nxt = db_cnt + DB_ONE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state      <= IDLE;
      db_cnt     <= '0;
      hold_cnt   <= '0;
      long_done  <= 1'b0;
      level      <= 1'b0;
      press      <= 1'b0;
      released   <= 1'b0;
      long_press <= 1'b0;
    end else begin
      state      <= state_nxt;
      db_cnt     <= db_cnt_nxt;
      hold_cnt   <= hold_cnt_nxt;
      long_done  <= long_done_nxt;
      level      <= level_nxt;
      press      <= press_nxt;
      released   <= released_nxt;
      long_press <= long_nxt;
    end
  end

endmodule

// File: rtl/key_input_ctrl.sv
// Board push-button block: NUM_KEYS independent debounced channels plus a press counter.
// Latency: pulses DB_CYC+2 edges after a clean input change; press_cnt one cycle after key_press.
// Backpressure: none; all outputs are registered and free-running.
//
// Ports:
//   clock, n_reset  system clock, asynchronous active-low reset
//   key_in          raw asynchronous button pins
//   key_level       debounced pressed level per key (1 = pressed)
//   key_press       1-cycle pulse per key on an accepted press
//   key_release     1-cycle pulse per key on an accepted release
//   key_long        1-cycle pulse per key when a hold reaches LONG_CYC
//   press_cnt       running total of accepted presses over all keys, wraps mod 2^CNT_W
module key_input_ctrl
  import key_pkg::*;
#(
  parameter int unsigned NUM_KEYS   = 4,
  parameter int unsigned DB_CYC     = 2000000,
  parameter int unsigned LONG_CYC   = 100000000,
  parameter bit          ACTIVE_LOW = 1'b1,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                clock,
  input  logic                n_reset,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_level,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long,
  output logic [CNT_W-1:0]    press_cnt
);

  logic [CNT_W-1:0] press_sum;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
    key_channel #(
      .DB_CYC     (DB_CYC),
      .LONG_CYC   (LONG_CYC),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_channel (
      .clock      (clock),
      .n_reset    (n_reset),
      .key_raw    (key_in[i]),
      .level      (key_level[i]),
      .press      (key_press[i]),
      .released   (key_release[i]),
      .long_press (key_long[i])
    );
  end

  // Popcount of the registered press pulses, so presses landing on several
  // keys in the same cycle are all counted.
  always_comb begin
    press_sum = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      press_sum = press_sum + CNT_W'(key_press[i]);
    end
  end

  // Wraps silently modulo 2^CNT_W.
  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      press_cnt <= '0;
    end else begin
      press_cnt <= press_cnt + press_sum;
    end
  end

endmodule

// File: tb/tb_key_input_ctrl.sv
// Self-checking bench for key_input_ctrl with short debounce/hold windows.
// Latency: n/a.
// Backpressure: n/a.
module tb_key_input_ctrl;

  localparam int NK   = 4;
  localparam int DB   = 4;
  localparam int LONG = 16;
  localparam int CW   = 8;

  logic          clock   = 1'b0;
  logic          n_reset = 1'b0;
  logic [NK-1:0] key_in  = '1;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic [NK-1:0] key_long;
  logic [CW-1:0] press_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  key_input_ctrl #(
    .NUM_KEYS   (NK),
    .DB_CYC     (DB),
    .LONG_CYC   (LONG),
    .ACTIVE_LOW (1'b1),
    .CNT_W      (CW)
  ) dut (
    .clock       (clock),
    .n_reset     (n_reset),
    .key_in      (key_in),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .key_long    (key_long),
    .press_cnt   (press_cnt)
  );

  always #5 clock = ~clock;

  // Reference model. Each key's pressed value reaches the decision logic two
  // samples after it is taken from the pin. A level change is accepted once
  // the new value has been seen on DB+1 consecutive samples. The hold timer
  // advances on every sample where the key was pressed on this and the
  // previous sample while the level is up.
  logic [NK-1:0] m_s1    = '1;
  logic [NK-1:0] m_s2    = '1;
  logic [NK-1:0] m_level = '0;
  logic [NK-1:0] m_press = '0;
  logic [NK-1:0] m_release = '0;
  logic [NK-1:0] m_long  = '0;
  logic [NK-1:0] m_pprev = '0;
  logic [NK-1:0] m_ldone = '0;
  logic [CW-1:0] m_cnt   = '0;
  int            m_run1[NK];
  int            m_run0[NK];
  int            m_hold[NK];
  logic          m_pk;

  always @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      m_s1 = '1; m_s2 = '1; m_level = '0; m_press = '0; m_release = '0;
      m_long = '0; m_pprev = '0; m_ldone = '0; m_cnt = '0;
      for (int k = 0; k < NK; k++) begin
        m_run1[k] = 0; m_run0[k] = 0; m_hold[k] = 0;
      end
    end else begin
      m_cnt = m_cnt + CW'($countones(m_press));
      for (int k = 0; k < NK; k++) begin
        m_pk = ~m_s2[k];
        m_press[k] = 1'b0; m_release[k] = 1'b0; m_long[k] = 1'b0;
        if (m_pk) begin m_run1[k]++; m_run0[k] = 0; end
        else      begin m_run0[k]++; m_run1[k] = 0; end
        if (!m_level[k] && m_run1[k] == DB + 1) begin
          m_press[k] = 1'b1; m_level[k] = 1'b1; m_hold[k] = 0; m_ldone[k] = 1'b0;
        end else if (m_level[k] && m_run0[k] == DB + 1) begin
          m_release[k] = 1'b1; m_level[k] = 1'b0;
        end else if (m_level[k] && m_pprev[k] && m_pk && !m_ldone[k]) begin
          m_hold[k]++;
          if (m_hold[k] == LONG - 1) begin m_long[k] = 1'b1; m_ldone[k] = 1'b1; end
        end
        m_pprev[k] = m_pk;
      end
      m_s2 = m_s1;
      m_s1 = key_in;
    end
  end

  wire [4*NK+CW-1:0] dut_vec = {key_level, key_press, key_release, key_long, press_cnt};
  wire [4*NK+CW-1:0] mdl_vec = {m_level, m_press, m_release, m_long, m_cnt};

  task automatic test_reset();
    repeat (3) @(negedge clock);
    n_cmp++; if (key_level !== '0) begin n_bad++; $display("FAIL reset_level: got %b want 0", key_level); end
    n_cmp++; if (key_press !== '0) begin n_bad++; $display("FAIL reset_press: got %b want 0", key_press); end
    n_cmp++; if (key_release !== '0) begin n_bad++; $display("FAIL reset_release: got %b want 0", key_release); end
    n_cmp++; if (key_long !== '0) begin n_bad++; $display("FAIL reset_long: got %b want 0", key_long); end
    n_cmp++; if (press_cnt !== '0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", press_cnt); end
    n_reset = 1'b1;
  endtask

  task automatic test_clean_press();
    int first = -1;
    int pulses = 0;
    key_in[0] = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      n_cmp++; if (dut_vec !== mdl_vec) begin n_bad++; $display("FAIL clean_cycle%0d: got %h want %h", c, dut_vec, mdl_vec); end
      if (key_press[0]) begin pulses++; if (first < 0) first = c; end
    end
    // First edge sampling the low pin is edge 1; the pulse is 6 edges later.
    n_cmp++; if (first != 7) begin n_bad++; $display("FAIL clean_latency: got %0d want 7", first); end
    n_cmp++; if (pulses != 1) begin n_bad++; $display("FAIL clean_width: got %0d want 1", pulses); end
    n_cmp++; if (key_level[0] !== 1'b1) begin n_bad++; $display("FAIL clean_level: got %b want 1", key_level[0]); end
    n_cmp++; if (press_cnt !== 8'd1) begin n_bad++; $display("FAIL clean_cnt: got %0d want 1", press_cnt); end
  endtask

  task automatic test_glitch();
    logic [CW-1:0] cnt_before = m_cnt;
    int pulses = 0;
    logic lvl_seen = 1'b0;
    key_in[1] = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      n_cmp++; if (dut_vec !== mdl_vec) begin n_bad++; $display("FAIL glitch_cycle%0d: got %h want %h", c, dut_vec, mdl_vec); end
      if (c == 3) key_in[1] = 1'b1;
      pulses += int'(key_press[1]) + int'(key_release[1]) + int'(key_long[1]);
      lvl_seen |= key_level[1];
    end
    n_cmp++; if (pulses != 0) begin n_bad++; $display("FAIL glitch_pulses: got %0d want 0", pulses); end
    n_cmp++; if (lvl_seen !== 1'b0) begin n_bad++; $display("FAIL glitch_level: got %b want 0", lvl_seen); end
    n_cmp++; if (press_cnt !== cnt_before) begin n_bad++; $display("FAIL glitch_cnt: got %0d want %0d", press_cnt, cnt_before); end
  endtask

  task automatic test_release_bounce();
    int rel = 0;
    key_in[0] = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      n_cmp++; if (dut_vec !== mdl_vec) begin n_bad++; $display("FAIL bounce_cycle%0d: got %h want %h", c, dut_vec, mdl_vec); end
      if (c == 2) key_in[0] = 1'b0;
      rel += int'(key_release[0]);
    end
    n_cmp++; if (rel != 0) begin n_bad++; $display("FAIL bounce_release: got %0d want 0", rel); end
    key_in[0] = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      n_cmp++; if (dut_vec !== mdl_vec) begin n_bad++; $display("FAIL release_cycle%0d: got %h want %h", c, dut_vec, mdl_vec); end
      rel += int'(key_release[0]);
    end
    n_cmp++; if (rel != 1) begin n_bad++; $display("FAIL release_count: got %0d want 1", rel); end
    n_cmp++; if (key_level[0] !== 1'b0) begin n_bad++; $display("FAIL release_level: got %b want 0", key_level[0]); end
  endtask

  // bounce_at = 0 means an unbroken hold. Otherwise the pin goes high for
  // 3 cycles starting bounce_at cycles after the press pulse.
  task automatic run_long(input int bounce_at, input int want_first, input string tag);
    bit found = 1'b0;
    int first = -1;
    int longs = 0;
    key_in[2] = 1'b0;
    for (int c = 0; c < 12 && !found; c++) begin
      @(negedge clock);
      n_cmp++; if (dut_vec !== mdl_vec) begin n_bad++; $display("FAIL %s_wait%0d: got %h want %h", tag, c, dut_vec, mdl_vec); end
      if (key_press[2]) found = 1'b1;
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL %s_press: got none want key_press[2] within 12", tag); end
    for (int c = 1; c <= 30; c++) begin
      @(negedge clock);
      n_cmp++; if (dut_vec !== mdl_vec) begin n_bad++; $display("FAIL %s_cycle%0d: got %h want %h", tag, c, dut_vec, mdl_vec); end
      if (bounce_at != 0 && c == bounce_at) key_in[2] = 1'b1;
      if (bounce_at != 0 && c == bounce_at + 3) key_in[2] = 1'b0;
      if (key_long[2]) begin longs++; if (first < 0) first = c; end
    end
    n_cmp++; if (first != want_first) begin n_bad++; $display("FAIL %s_delay: got %0d want %0d", tag, first, want_first); end
    n_cmp++; if (longs != 1) begin n_bad++; $display("FAIL %s_count: got %0d want 1", tag, longs); end
    key_in[2] = 1'b1;
    repeat (12) begin
      @(negedge clock);
      n_cmp++; if (dut_vec !== mdl_vec) begin n_bad++; $display("FAIL %s_drain: got %h want %h", tag, dut_vec, mdl_vec); end
    end
  endtask

  task automatic test_long_press();
    // Unbroken hold: the pulse lands LONG-1 cycles after key_press.
    run_long(0, 15, "long");
    // Bounce from cycle 3: the timer does not advance on the sample that
    // leaves the hold, the two samples inside the release window, or the
    // sample that resumes it -> 4 extra cycles.
    run_long(3, 19, "long_bounce");
  endtask

  task automatic test_random();
    int remain[NK];
    for (int k = 0; k < NK; k++) remain[k] = $urandom_range(1, 24);
    for (int c = 0; c < 800; c++) begin
      @(negedge clock);
      n_cmp++; if (dut_vec !== mdl_vec) begin n_bad++; $display("FAIL random_cycle%0d: got %h want %h", c, dut_vec, mdl_vec); end
      for (int k = 0; k < NK; k++) begin
        remain[k]--;
        if (remain[k] <= 0) begin
          key_in[k] = ~key_in[k];
          remain[k] = $urandom_range(1, 24);
        end
      end
    end
    key_in = '1;
    repeat (14) begin
      @(negedge clock);
      n_cmp++; if (dut_vec !== mdl_vec) begin n_bad++; $display("FAIL random_drain: got %h want %h", dut_vec, mdl_vec); end
    end
  endtask

  task automatic test_simul_wrap();
    logic [NK-1:0] mask;
    logic [CW-1:0] need;
    bit found = 1'b0;
    for (int r = 0; r < 400 && m_cnt != 8'd254; r++) begin
      need = 8'd254 - m_cnt;
      mask = NK'($urandom_range(1, 15));
      while ($countones(mask) > int'(need)) mask = mask & (mask - 1'b1);
      key_in = ~mask;
      repeat (8) @(negedge clock);
      key_in = '1;
      repeat (10) @(negedge clock);
      n_cmp++; if (press_cnt !== m_cnt) begin n_bad++; $display("FAIL wrap_round%0d: got %0d want %0d", r, press_cnt, m_cnt); end
    end
    n_cmp++; if (press_cnt !== 8'd254) begin n_bad++; $display("FAIL wrap_setup: got %0d want 254", press_cnt); end
    key_in = '0;
    for (int c = 0; c < 12 && !found; c++) begin
      @(negedge clock);
      n_cmp++; if (dut_vec !== mdl_vec) begin n_bad++; $display("FAIL simul_cycle%0d: got %h want %h", c, dut_vec, mdl_vec); end
      if (|key_press) found = 1'b1;
    end
    n_cmp++; if (key_press !== 4'b1111) begin n_bad++; $display("FAIL simul_press: got %b want 1111", key_press); end
    @(negedge clock);
    n_cmp++; if (press_cnt !== 8'd2) begin n_bad++; $display("FAIL simul_wrap: got %0d want 2", press_cnt); end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    int first = -1;
    key_in = '1;
    repeat (14) @(negedge clock);
    key_in[0] = 1'b0;
    repeat (4) @(negedge clock);
    // Key 0 is debouncing and press_cnt is non-zero here.
    #2 n_reset = 1'b0;
    #1;
    n_cmp++; if (dut_vec !== '0) begin n_bad++; $display("FAIL reset_pressdb: got %h want 0", dut_vec); end
    @(negedge clock);
    n_reset = 1'b1;
    for (int c = 0; c < 12 && !found; c++) begin
      @(negedge clock);
      n_cmp++; if (dut_vec !== mdl_vec) begin n_bad++; $display("FAIL rmid_cycle%0d: got %h want %h", c, dut_vec, mdl_vec); end
      if (key_press[0]) found = 1'b1;
    end
    n_cmp++; if (!found) begin n_bad++; $display("FAIL rmid_press: got none want key_press[0] within 12"); end
    repeat (3) @(negedge clock);
    #2 n_reset = 1'b0;
    #1;
    n_cmp++; if (dut_vec !== '0) begin n_bad++; $display("FAIL reset_held: got %h want 0", dut_vec); end
    @(negedge clock);
    n_reset = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clock);
      n_cmp++; if (dut_vec !== mdl_vec) begin n_bad++; $display("FAIL rpost_cycle%0d: got %h want %h", c, dut_vec, mdl_vec); end
      if (key_press[0] && first < 0) first = c;
    end
    n_cmp++; if (first != 7) begin n_bad++; $display("FAIL rpost_latency: got %0d want 7", first); end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_release_bounce();
    test_long_press();
    test_random();
    test_simul_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
